// File: rtl/cache_arb_pkg.sv
// Shared types and tag-field constants for the two-client cache arbiter.
// Tag layout: bit 12 is READ=1/WRITE=0, bits 11:8 flag MEMORY/MMIO/PORT/IRQ.
package cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MREQ,
      MWAIT,
      CRESP
   } arb_state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } gnt_e;

   localparam int unsigned TAG_RW_BIT     = 12;
   localparam int unsigned TAG_MEMORY_BIT = 11;
   localparam int unsigned TAG_MMIO_BIT   = 10;
   localparam int unsigned TAG_PORT_BIT   = 9;
   localparam int unsigned TAG_IRQ_BIT    = 8;

endpackage

// File: rtl/cache_arbiter_bus.sv
// Request/response bus between a cache client, the arbiter and memory.
// ArbiterPorts is the arbiter's view of a client; CachePorts is the arbiter acting as requester.
interface CacheArbiterBus #(
   parameter int DATA_WIDTH = 512,
   parameter int ADDRESS    = 64,
   parameter int TAG_WIDTH  = 13
);

   logic                  reqcyc;
   logic                  reqack;
   logic [ADDRESS-1:0]    req;
   logic [DATA_WIDTH-1:0] reqdata;
   logic [TAG_WIDTH-1:0]  reqtag;
   logic                  respcyc;
   logic                  respack;
   logic [DATA_WIDTH-1:0] resp;
   logic [TAG_WIDTH-1:0]  resptag;

   modport ArbiterPorts (
      input  reqcyc, req, reqdata, reqtag, respack,
      output reqack, respcyc, resp, resptag
   );

   modport CachePorts (
      output reqcyc, req, reqdata, reqtag, respack,
      input  reqack, respcyc, resp, resptag
   );

endinterface

// File: rtl/arb_grant2.sv
// Two-way grant decision: DCache wins ties by default; with ARB_ROUND_ROBIN_EN defined the
// client not granted last wins ties, tracked by a pointer updated on every acceptance.
module arb_grant2
   import cache_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
   input  logic clk,
   input  logic reset,
   input  logic accept_i,
`endif
   input  logic ireq_i,
   input  logic dreq_i,
   output logic valid_o,
   output gnt_e gnt_o
);

   assign valid_o = ireq_i | dreq_i;

`ifdef ARB_ROUND_ROBIN_EN
   gnt_e last_q, last_d;

   always_comb begin
      gnt_o  = GNT_I;
      last_d = last_q;
      if (ireq_i && dreq_i) begin
         gnt_o = (last_q == GNT_D) ? GNT_I : GNT_D;
      end else if (dreq_i) begin
         gnt_o = GNT_D;
      end
      if (accept_i && valid_o) begin
         last_d = gnt_o;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= GNT_D;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign gnt_o = dreq_i ? GNT_D : GNT_I;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates ICache and DCache onto one memory bus with a single outstanding transaction.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise DCache has fixed priority.
module cache_arbiter
   import cache_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int ADDRESS    = 64,
   parameter int TAG_WIDTH  = 13
) (
   input logic                  clk,
   input logic                  reset,
   CacheArbiterBus.ArbiterPorts ibus,
   CacheArbiterBus.ArbiterPorts dbus,
   CacheArbiterBus.CachePorts   mbus
);

   arb_state_e            state_q, state_d;
   gnt_e                  owner_q, owner_d;
   logic [ADDRESS-1:0]    req_q, req_d;
   logic [DATA_WIDTH-1:0] reqdata_q, reqdata_d;
   logic [TAG_WIDTH-1:0]  reqtag_q, reqtag_d;
   logic [DATA_WIDTH-1:0] resp_q, resp_d;
   logic [TAG_WIDTH-1:0]  resptag_q, resptag_d;

   logic gnt_valid;
   gnt_e gnt;
   logic accept;
   logic owner_respack;

   arb_grant2 u_grant (
`ifdef ARB_ROUND_ROBIN_EN
      .clk      (clk),
      .reset    (reset),
      .accept_i (state_q == IDLE),
`endif
      .ireq_i   (ibus.reqcyc),
      .dreq_i   (dbus.reqcyc),
      .valid_o  (gnt_valid),
      .gnt_o    (gnt)
   );

   assign accept        = (state_q == IDLE) && gnt_valid;
   assign owner_respack = (owner_q == GNT_D) ? dbus.respack : ibus.respack;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      req_d     = req_q;
      reqdata_d = reqdata_q;
      reqtag_d  = reqtag_q;
      resp_d    = resp_q;
      resptag_d = resptag_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               owner_d = gnt;
               if (gnt == GNT_D) begin
                  req_d     = dbus.req;
                  reqdata_d = dbus.reqdata;
                  reqtag_d  = dbus.reqtag;
               end else begin
                  req_d     = ibus.req;
                  reqdata_d = ibus.reqdata;
                  reqtag_d  = ibus.reqtag;
               end
               state_d = MREQ;
            end
         end
         MREQ: begin
            if (mbus.reqack) begin
               state_d = MWAIT;
            end
         end
         MWAIT: begin
            if (mbus.respcyc) begin
               resp_d    = mbus.resp;
               resptag_d = mbus.resptag;
               state_d   = CRESP;
            end
         end
         CRESP: begin
            if (owner_respack) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         owner_q   <= GNT_D;
         req_q     <= '0;
         reqdata_q <= '0;
         reqtag_q  <= '0;
         resp_q    <= '0;
         resptag_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         req_q     <= req_d;
         reqdata_q <= reqdata_d;
         reqtag_q  <= reqtag_d;
         resp_q    <= resp_d;
         resptag_q <= resptag_d;
      end
   end

   // The ack is combinational from the request, so it must be masked while reset is held.
   assign ibus.reqack  = reset && accept && (gnt == GNT_I);
   assign dbus.reqack  = reset && accept && (gnt == GNT_D);
   assign ibus.respcyc = (state_q == CRESP) && (owner_q == GNT_I);
   assign dbus.respcyc = (state_q == CRESP) && (owner_q == GNT_D);
   assign ibus.resp    = resp_q;
   assign ibus.resptag = resptag_q;
   assign dbus.resp    = resp_q;
   assign dbus.resptag = resptag_q;

   assign mbus.reqcyc  = (state_q == MREQ);
   assign mbus.req     = req_q;
   assign mbus.reqdata = reqdata_q;
   assign mbus.reqtag  = reqtag_q;
   assign mbus.respack = (state_q == MWAIT) && mbus.respcyc;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 512, SHALL set the line data width on every bus.
REQ-002 Parameter ADDRESS, default 64, SHALL set the request address width.
REQ-003 Parameter TAG_WIDTH, default 13, SHALL set the tag width: bit 12 is READ=1/WRITE=0, bits 11:8 are MEMORY/MMIO/PORT/IRQ.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 ibus  CacheArbiterBus.ArbiterPorts  -  SHALL be the ICache client port.
REQ-007 dbus  CacheArbiterBus.ArbiterPorts  -  SHALL be the DCache client port.
REQ-008 mbus  CacheArbiterBus.CachePorts  -  SHALL be the memory-side port; the arbiter is the requester here.

Function
REQ-009 The block SHALL allow one outstanding transaction, held by the granted client (owner) from acceptance until its response is acknowledged.
REQ-010 FSM states SHALL be IDLE, MREQ, MWAIT, CRESP.
REQ-011 In IDLE, with any client reqcyc high, the winner's req/reqdata/reqtag SHALL be latched, its reqack pulsed high for exactly one cycle, and the FSM moved to MREQ.
REQ-012 In MREQ, mbus.reqcyc SHALL be 1 with the latched req/reqdata/reqtag held stable until mbus.reqack is sampled high, then go to MWAIT with mbus.reqcyc deasserted.
REQ-013 In MWAIT, on mbus.respcyc high, mbus.resp/resptag SHALL be latched, mbus.respack pulsed for one cycle, and the FSM moved to CRESP.
REQ-014 In CRESP, owner respcyc SHALL be 1 with latched resp and resptag unchanged until owner respack is sampled high, then go to IDLE.
REQ-015 The non-owner's reqack and respcyc SHALL stay 0 throughout; its pending reqcyc is arbitrated on the next IDLE cycle.
REQ-016 Minimum latency, client reqcyc to client respcyc, SHALL be 3 cycles when mbus acks and responds immediately.
REQ-017 Respack and a new reqcyc in the same cycle SHALL be handled as: return to IDLE that edge, new acceptance the next edge (one idle bubble).
REQ-018 Writes (tag bit 12 = 0) SHALL follow the same sequence; a response is always required.
REQ-019 Client reqcyc dropped before reqack SHALL be ignored; no transaction is issued.

Reset
REQ-020 While reset is low: FSM=IDLE, all reqack/respcyc/respack/reqcyc outputs 0, all data/addr/tag outputs 0, and the round-robin pointer set to "last granted = DCache".
REQ-021 Reset mid-transaction SHALL discard the in-flight transaction with no replay; the first grant after release follows REQ-020.

Configuration
REQ-022 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the client not granted last; the pointer updates on each acceptance.
REQ-023 Without ARB_ROUND_ROBIN_EN, DCache SHALL always win simultaneous requests, and the pointer logic SHALL be absent.

Structure
REQ-024 Package cache_arb_pkg SHALL hold the FSM state enum, the grant enum (GNT_I, GNT_D), and tag field position constants.
REQ-025 Sub-module arb_grant2 SHALL implement the two-way grant decision, both policies, and the pointer; everything else stays in cache_arbiter.

Verification
REQ-026 ICache read only, addr 0x1000, tag 0x1001, mbus acks immediately and responds 2 cycles later with data 0xA5.. -> ibus.reqack 1 cycle; ibus.respcyc with resp 0xA5.., resptag 0x1001; dbus stays silent.
REQ-027 Both request in the same cycle after reset, round-robin on -> ICache served first, DCache next; round-robin off -> DCache first.
REQ-028 DCache write, tag 0x0001, data all-ones, mbus.reqack delayed 5 cycles -> mbus.reqcyc and data stable for all 5 cycles; single mbus.respack pulse.
REQ-029 Client holds respack low for 4 cycles -> respcyc, resp, and resptag held for 4 cycles; the waiting ICache reqcyc is not acked until IDLE.
REQ-030 Reset asserted in MWAIT -> all outputs 0 asynchronously; a later mbus.respcyc while idle is not acked; the next request completes normally.
